pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator_if.sv | 22 ++
 rtl/pwm_generator.sv | 72 +++++++
 tb/tb_pwm_generator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_if.sv
// Signal bundle between a PWM controller (master) and pwm_generator (slave).
interface pwm_generator_if #(
    parameter int WIDTH = 8
);
    logic             Tick_in;
    logic             Enable;
    logic [WIDTH-1:0] Duty_in;
    logic             Duty_load;
    logic             Pwm_out;
    logic             Period_done;
    logic [WIDTH-1:0] Duty_active;

    modport master (
        output Tick_in, Enable, Duty_in, Duty_load,
        input  Pwm_out, Period_done, Duty_active
    );

    modport slave (
        input  Tick_in, Enable, Duty_in, Duty_load,
        output Pwm_out, Period_done, Duty_active
    );
endinterface

// File: rtl/pwm_generator.sv
// Tick-driven PWM with a 2^WIDTH period; duty changes are applied at period wrap.
// Define PWM_SOFTSTART_EN to slew active duty by one step per wrap instead of jumping.
module pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic           Clk_in,
    input  logic           Rst,
    pwm_generator_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             tick_d;
    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] act_nxt;
    logic             pwm_q;
    logic             done_q;

    // Rising-edge detect of the upstream divided clock.
    assign tick = bus.Tick_in & ~tick_d;
    assign wrap = tick && (cnt == CNT_MAX);

    always_comb begin
        cnt_nxt = cnt + 1'b1;
        act_nxt = act_duty;
        if (wrap) begin
`ifdef PWM_SOFTSTART_EN
            if (act_duty < pend_duty)
                act_nxt = act_duty + 1'b1;
            else if (act_duty > pend_duty)
                act_nxt = act_duty - 1'b1;
`else
            act_nxt = pend_duty;
`endif
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            tick_d    <= 1'b0;
            cnt       <= '0;
            pend_duty <= '0;
            act_duty  <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_d <= bus.Tick_in;
            done_q <= 1'b0;
            // A load on the wrap edge lands here, after act_nxt already used the old value.
            if (bus.Duty_load)
                pend_duty <= bus.Duty_in;
            if (!bus.Enable) begin
                cnt      <= '0;
                pwm_q    <= 1'b0;
                act_duty <= pend_duty;
            end else if (tick) begin
                cnt      <= cnt_nxt;
                act_duty <= act_nxt;
                pwm_q    <= (cnt_nxt < act_nxt);
                done_q   <= wrap;
            end
        end
    end

    assign bus.Pwm_out     = pwm_q;
    assign bus.Period_done = done_q;
    assign bus.Duty_active = act_duty;
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator (WIDTH=8, Tick_in toggling every 4 clocks).
module tb_pwm_generator;
    localparam int WIDTH  = 8;
    localparam int TPER   = 8;            // clocks per tick
    localparam int PERIOD = 256 * TPER;   // clocks per PWM period

    logic Clk_in = 1'b0;
    logic Rst    = 1'b1;
    int   nvec   = 0;
    int   nfail  = 0;

    pwm_generator_if #(.WIDTH(WIDTH)) bus ();

    pwm_generator #(.WIDTH(WIDTH)) dut (
        .Clk_in (Clk_in),
        .Rst    (Rst),
        .bus    (bus)
    );

    always #5 Clk_in = ~Clk_in;

    initial begin
        bus.Tick_in = 1'b0;
        forever begin
            repeat (4) @(negedge Clk_in);
            bus.Tick_in = ~bus.Tick_in;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        int duty;
        int exp_highs;
        int exp_dones;
        int exp_active;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns at posedge+1 of the cycle in which Period_done is high.
    task automatic wait_pd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < PERIOD + 1000 && !seen; i++) begin
            @(posedge Clk_in); #1;
            seen = bus.Period_done;
        end
        if (!seen) begin
            nvec++;
            nfail++;
            $display("FAIL wait_pd: Period_done not seen, got 0, expected 1");
        end
    endtask

    task automatic load(input int d);
        @(negedge Clk_in);
        bus.Duty_in   = d[WIDTH-1:0];
        bus.Duty_load = 1'b1;
        @(negedge Clk_in);
        bus.Duty_load = 1'b0;
    endtask

    // Called in a Period_done cycle; scans exactly one period.
    task automatic measure(output int highs, output int dones);
        int hc;
        hc    = 0;
        dones = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) begin
                @(posedge Clk_in); #1;
            end
            if (bus.Pwm_out)     hc++;
            if (bus.Period_done) dones++;
        end
        highs = hc / TPER;
    endtask

    initial begin
        int   highs;
        int   dones;
        vec_t vt[4];

        vt[0] = '{duty: 0,   exp_highs: 0,   exp_dones: 1, exp_active: 0};
        vt[1] = '{duty: 255, exp_highs: 255, exp_dones: 1, exp_active: 255};
        vt[2] = '{duty: 1,   exp_highs: 1,   exp_dones: 1, exp_active: 1};
        vt[3] = '{duty: 128, exp_highs: 128, exp_dones: 1, exp_active: 128};

        bus.Enable    = 1'b0;
        bus.Duty_in   = '0;
        bus.Duty_load = 1'b0;

        repeat (3) @(posedge Clk_in);
        #1;
        check("rst_pwm",    bus.Pwm_out,     0);
        check("rst_done",   bus.Period_done, 0);
        check("rst_active", bus.Duty_active, 0);
        check("rst_cnt",    dut.cnt,         0);
        @(negedge Clk_in);
        Rst = 1'b0;

        // Disabled: active duty follows pending without waiting for a wrap.
        load(64);
        @(posedge Clk_in); #1;
        check("idle_track", bus.Duty_active, 64);

        @(negedge Clk_in);
        bus.Enable = 1'b1;
        wait_pd();
        measure(highs, dones);
        check("d64_highs", highs, 64);
        check("d64_dones", dones, 1);
        check("d64_active", bus.Duty_active, 64);

`ifndef PWM_SOFTSTART_EN
        foreach (vt[k]) begin
            wait_pd();
            load(vt[k].duty);
            wait_pd();
            measure(highs, dones);
            check($sformatf("vec%0d_highs", k), highs, vt[k].exp_highs);
            check($sformatf("vec%0d_dones", k), dones, vt[k].exp_dones);
            check($sformatf("vec%0d_active", k), bus.Duty_active, vt[k].exp_active);
        end

        // Load 100 exactly on the wrap edge: the wrap keeps 128.
        wait_pd();
        repeat (PERIOD - 1) @(posedge Clk_in);
        @(negedge Clk_in);
        bus.Duty_in   = 8'd100;
        bus.Duty_load = 1'b1;
        @(posedge Clk_in); #1;
        check("coinc_done",   bus.Period_done, 1);
        check("coinc_active", bus.Duty_active, 128);
        check("coinc_pend",   dut.pend_duty,   100);
        @(negedge Clk_in);
        bus.Duty_load = 1'b0;
        wait_pd();
        check("coinc_next_active", bus.Duty_active, 100);

        load(200);
        wait_pd();
`else
        @(negedge Clk_in);
        bus.Enable = 1'b0;
        load(10);
        @(posedge Clk_in); #1;
        check("ss_idle10", bus.Duty_active, 10);
        @(negedge Clk_in);
        bus.Enable = 1'b1;
        wait_pd();
        check("ss_hold10", bus.Duty_active, 10);
        load(13);
        wait_pd();
        check("ss_step11", bus.Duty_active, 11);
        wait_pd();
        check("ss_step12", bus.Duty_active, 12);
        wait_pd();
        check("ss_step13", bus.Duty_active, 13);
        load(12);
        wait_pd();
        check("ss_down12", bus.Duty_active, 12);
`endif

        // Reset mid-period at count 130.
        repeat (130 * TPER) @(posedge Clk_in);
        #1;
        check("pre_rst_cnt", dut.cnt, 130);
`ifndef PWM_SOFTSTART_EN
        check("pre_rst_pwm", bus.Pwm_out, 1);
`endif
        @(negedge Clk_in);
        Rst = 1'b1;
        @(posedge Clk_in); #1;
        check("mid_rst_cnt",    dut.cnt,         0);
        check("mid_rst_pwm",    bus.Pwm_out,     0);
        check("mid_rst_active", bus.Duty_active, 0);
        check("mid_rst_pend",   dut.pend_duty,   0);
        check("mid_rst_done",   bus.Period_done, 0);
        @(negedge Clk_in);
        Rst = 1'b0;

        // Drop Enable mid-period with 50 pending.
        load(50);
        repeat (300) @(posedge Clk_in);
        #1;
        check("pre_dis_active", bus.Duty_active, 0);
        @(negedge Clk_in);
        bus.Enable = 1'b0;
        @(posedge Clk_in); #1;
        check("dis_pwm",    bus.Pwm_out,     0);
        check("dis_cnt",    dut.cnt,         0);
        check("dis_active", bus.Duty_active, 50);
        check("dis_done",   bus.Period_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
